aes_inv_cipher_iter: RTL and testbench
======================================

// Module: aes_inv_cipher_iter
// PURPOSE
//  Iterative AES inverse cipher (decryption), the receive-side counterpart of the AES encryption core.
//  Accepts a 128-bit ciphertext and a cipher key over a valid/ready handshake.
//  Expands the key internally, one word per cycle, then runs one inverse round per cycle.
//  Returns the plaintext over a valid/ready handshake. Nr/Nk parameters match the encryption core.
//  Legal configurations: (10,4) AES-128, (12,6) AES-192, (14,8) AES-256.
// PARAMETERS
//  NR  10  number of rounds (10/12/14)
//  NK  4   key length in 32-bit words (4/6/8); any other (NR,NK) pair -> elaboration-time $error
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  in_valid   in   1        ct/key valid
//  in_ready   out  1        block can accept; high only in IDLE
//  ct         in   128      ciphertext, byte 0 = ct[127:120]
//  key        in   32*NK    cipher key, word 0 = key[32*NK-1 -: 32]
//  out_valid  out  1        pt valid; held until out_ready
//  out_ready  in   1        sink accepts pt
//  pt         out  128      plaintext
//  busy       out  1        high in KEXP/INIT/ROUND/DONE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, in_ready=0 during reset then 1, out_valid=0, busy=0, pt=0,
//   key store cleared, round counter=0. Reset mid-operation aborts; no partial pt is ever flagged.
//  FSM: IDLE -> KEXP -> INIT -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready (accept edge), latch ct into state reg and words w[0..NK-1].
//   Go to KEXP. in_valid without a handshake is ignored.
//  KEXP: K=4*(NR+1)-NK cycles (AES-128 40, AES-192 46, AES-256 52). Each cycle computes w[i] = w[i-NK]^temp.
//   i mod NK==0: temp=SubWord(RotWord(w[i-1]))^Rcon.
//   NK==8 && i mod NK==4: temp=SubWord(w[i-1]).
//   Otherwise: temp=w[i-1].
//   Rcon is a byte register, starting 8'h01 and advanced by xtime (8'h1b reduction) after each use.
//  INIT: 1 cycle, state ^= rk[NR]; round counter r=NR-1.
//  ROUND: 1 cycle per round.
//   r>=1: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])); then r--.
//   r==0 (final): state = InvSubBytes(InvShiftRows(state)) ^ rk[0]; copy to pt; go to DONE.
//  DONE: out_valid=1; pt stable. On out_ready: out_valid=0 next edge, back to IDLE, in_ready=1 the cycle after.
//   out_ready high while out_valid=0 has no effect. pt keeps its last value after the handshake.
//  Latency (accept edge = edge 0, no backpressure): out_valid high after edge K+NR+1.
//   AES-128 51, AES-192 59, AES-256 67.
//  Throughput: one block in flight; no new accept until the DONE handshake.
//  Arithmetic: all GF(2^8); xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
//   InvMixColumns uses the 0e/0b/0d/09 multipliers built from xtime chains.
//  S-box logic: 4 forward S-box byte lookups (key path) and 16 inverse S-box lookups (data path),
//   all combinational.
// CONFIGURATION
//  AES_DEC_KEY_CACHE_EN defined:
//   - The expanded key (4*(NR+1) words) is retained after DONE, with a key_cached flag (reset 0).
//   - On accept, if key_cached && key equals the stored w[0..NK-1], skip KEXP and go straight to INIT.
//     Latency is then NR+1 (AES-128 11, AES-192 13, AES-256 15).
//   - A key mismatch runs full KEXP and refreshes the cache.
//   - Reset clears key_cached.
//  Not defined: every accept runs KEXP; no retention or compare logic.
// TESTING
//  1. AES-128, key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1
//     -> pt 00112233445566778899aabbccddeeff, out_valid after edge 51.
//  2. AES-192 (NR=12,NK=6), key 000102..17, ct dda97ca4864cdfe06eaf70a0ec0d7191
//     -> same pt, out_valid after edge 59.
//  3. AES-256 (NR=14,NK=8), key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089
//     -> same pt, out_valid after edge 67.
//  4. Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and pt held stable, in_ready=0.
//     Then out_ready pulse -> out_valid=0 and in_ready=1 on the following cycles.
//     in_valid held high during ROUND -> no second accept.
//  5. reset=0 asynchronously at KEXP word 20 -> out_valid/busy/pt=0 immediately.
//     After release, vector 1 decrypts correctly with latency 51.
//  6. AES_DEC_KEY_CACHE_EN: vector 1 twice back-to-back -> latencies 51 then 11, both pt correct.
//     Then a different key -> latency 51.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher (decryption).
// Accepts ciphertext and cipher key over valid/ready. Expands the key one word per
// cycle, then runs one inverse round per cycle. Returns the plaintext over valid/ready.
// Optional macro AES_DEC_KEY_CACHE_EN keeps the expanded key after a block, so a later
// block under the same key can skip key expansion.
module aes_inv_cipher_iter #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    ct,
  input  logic [32*NK-1:0] key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    pt,
  output logic            busy
);

  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LAST6 = 6'(NW - 1);
  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [2:0] NKM1  = 3'(NK - 1);

  generate
    if (!((NR == 10 && NK == 4) || (NR == 12 && NK == 6) || (NR == 14 && NK == 8))) begin : gBadConfig
      $error("aes_inv_cipher_iter: unsupported NR/NK pair");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_e;

  // Table entry for byte b sits at index ~b (first listed byte lands at the top).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using the xtime chain b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {SBOX[~x[31:24]], SBOX[~x[23:16]], SBOX[~x[15:8]], SBOX[~x[7:0]]};
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[127 - 8*n -: 8] = INV_SBOX[~s[127 - 8*n -: 8]];
    end
    return o;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    return {invMixCol(s[127:96]), invMixCol(s[95:64]), invMixCol(s[63:32]), invMixCol(s[31:0])};
  endfunction

  state_e        state_q, state_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  pt_q, pt_d;
  logic [3:0]    round_q, round_d;
  logic [5:0]    keyIdx_q, keyIdx_d;
  logic [2:0]    keyMod_q, keyMod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [31:0]   w_q [NW];
  logic [31:0]   w_d [NW];

  logic [5:0]    prevIdx, farIdx, rkBase;
  logic [31:0]   prevWord, subIn, subOut, keyTemp, newWord;
  logic [127:0]  roundKey, isr, isb, ark, imc;
  logic          needKexp;

  assign prevIdx  = keyIdx_q - 6'd1;
  assign farIdx   = keyIdx_q - NK6;
  assign prevWord = w_q[prevIdx];
  assign subIn    = (keyMod_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
  assign subOut   = subWord(subIn);

  // Pick the key-schedule temp word by the word's position within the key length
  always_comb begin
    if (keyMod_q == 3'd0) begin
      keyTemp = subOut ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && keyMod_q == 3'd4) begin
      keyTemp = subOut;
    end else begin
      keyTemp = prevWord;
    end
  end

  assign newWord  = w_q[farIdx] ^ keyTemp;

  assign rkBase   = (state_q == INIT) ? {NR4, 2'b00} : {round_q, 2'b00};
  assign roundKey = {w_q[rkBase], w_q[rkBase + 6'd1], w_q[rkBase + 6'd2], w_q[rkBase + 6'd3]};
  assign isr      = invShiftRows(data_q);
  assign isb      = invSubBytes(isr);
  assign ark      = isb ^ roundKey;
  assign imc      = invMixColumns(ark);

`ifdef AES_DEC_KEY_CACHE_EN
  logic             keyCached_q, keyCached_d;
  logic [32*NK-1:0] storedKey;

  // Reassemble the stored original key words so a new key can be compared against them
  always_comb begin
    storedKey = '0;
    for (int j = 0; j < NK; j++) begin
      storedKey[32*NK-1-32*j -: 32] = w_q[j];
    end
  end

  assign needKexp = !(keyCached_q && (key == storedKey));
`else
  assign needKexp = 1'b1;
`endif

  // Next-state logic: handshake, key expansion steps and inverse rounds
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    pt_d     = pt_q;
    round_d  = round_q;
    keyIdx_d = keyIdx_q;
    keyMod_d = keyMod_q;
    rcon_d   = rcon_q;
    w_d      = w_q;
`ifdef AES_DEC_KEY_CACHE_EN
    keyCached_d = keyCached_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d = ct;
          if (needKexp) begin
            for (int j = 0; j < NK; j++) begin
              w_d[j] = key[32*NK-1-32*j -: 32];
            end
            keyIdx_d = NK6;
            keyMod_d = 3'd0;
            rcon_d   = 8'h01;
            state_d  = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
            keyCached_d = 1'b0;
`endif
          end else begin
            state_d = INIT;
          end
        end
      end
      KEXP: begin
        w_d[keyIdx_q] = newWord;
        keyIdx_d = keyIdx_q + 6'd1;
        keyMod_d = (keyMod_q == NKM1) ? 3'd0 : keyMod_q + 3'd1;
        if (keyMod_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (keyIdx_q == LAST6) begin
          state_d = INIT;
`ifdef AES_DEC_KEY_CACHE_EN
          keyCached_d = 1'b1;
`endif
        end
      end
      INIT: begin
        data_d  = data_q ^ roundKey;
        round_d = NR4 - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        if (round_q != 4'd0) begin
          data_d  = imc;
          round_d = round_q - 4'd1;
        end else begin
          data_d  = ark;
          pt_d    = ark;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight and clears the key store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      pt_q     <= '0;
      round_q  <= '0;
      keyIdx_q <= '0;
      keyMod_q <= '0;
      rcon_q   <= 8'h01;
      w_q      <= '{default: '0};
`ifdef AES_DEC_KEY_CACHE_EN
      keyCached_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      pt_q     <= pt_d;
      round_q  <= round_d;
      keyIdx_q <= keyIdx_d;
      keyMod_q <= keyMod_d;
      rcon_q   <= rcon_d;
      w_q      <= w_d;
`ifdef AES_DEC_KEY_CACHE_EN
      keyCached_q <= keyCached_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && reset;
  assign out_valid = (state_q == DONE);
  assign pt        = pt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed bench for aes_inv_cipher_iter using the FIPS-197
// known-answer vectors for AES-128/192/256, with a scoreboard of expected plaintext
// and latency for the AES-128 instance.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic reset;

  logic         inValid, inReady, outValid, outReady, busy128;
  logic [127:0] ct128, key128, pt128;

  logic         inValidB, outReadyB;
  logic         inReady192, outValid192, busy192;
  logic         inReady256, outValid256, busy256;
  logic [127:0] ct192, pt192, ct256, pt256;
  logic [191:0] key192;
  logic [255:0] key256;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] pt;
    int           lat;
  } exp_t;

  exp_t sbQ[$];

  localparam logic [127:0] KEY_V1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_V1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_V   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int CACHED_LAT = 11;
`else
  localparam int CACHED_LAT = 51;
`endif

  aes_inv_cipher_iter #(.NR(10), .NK(4)) dut128 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .ct(ct128), .key(key128), .out_valid(outValid), .out_ready(outReady),
    .pt(pt128), .busy(busy128)
  );

  aes_inv_cipher_iter #(.NR(12), .NK(6)) dut192 (
    .clk(clk), .reset(reset), .in_valid(inValidB), .in_ready(inReady192),
    .ct(ct192), .key(key192), .out_valid(outValid192), .out_ready(outReadyB),
    .pt(pt192), .busy(busy192)
  );

  aes_inv_cipher_iter #(.NR(14), .NK(8)) dut256 (
    .clk(clk), .reset(reset), .in_valid(inValidB), .in_ready(inReady256),
    .ct(ct256), .key(key256), .out_valid(outValid256), .out_ready(outReadyB),
    .pt(pt256), .busy(busy256)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Safety net in case the sequence below stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] c, input logic [127:0] k,
                               input logic [127:0] expPt, input int expLat,
                               input bit holdValid, input string tag);
    exp_t e;
    @(negedge clk);
    ct128   = c;
    key128  = k;
    inValid = 1'b1;
    checkBit({tag, "_inReady"}, inReady, 1'b1);
    e.pt  = expPt;
    e.lat = expLat;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (!holdValid) inValid = 1'b0;
    checkBit({tag, "_busyAfterAccept"}, busy128, 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   cnt;
    checkInt({tag, "_sbDepth"}, sbQ.size(), 1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    cnt = 0;
    while (!outValid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkBit({tag, "_outValid"}, outValid, 1'b1);
    checkInt({tag, "_latency"}, cnt, e.lat);
    checkVal({tag, "_pt"}, pt128, e.pt);
    checkBit({tag, "_busyDone"}, busy128, 1'b1);
  endtask

  task automatic finishHandshake(input string tag);
    @(posedge clk);
    #1;
    checkBit({tag, "_outValidDrop"}, outValid, 1'b0);
    checkBit({tag, "_inReadyBack"}, inReady, 1'b1);
  endtask

  initial begin
    int cnt, lat192, lat256;

    reset     = 1'b0;
    inValid   = 1'b0;
    outReady  = 1'b1;
    ct128     = '0;
    key128    = '0;
    inValidB  = 1'b0;
    outReadyB = 1'b1;
    ct192     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    key192    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    ct256     = 128'h8ea2b7ca516745bfeafc49904b496089;
    key256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkBit("rst_inReady", inReady, 1'b0);
    checkBit("rst_outValid", outValid, 1'b0);
    checkBit("rst_busy", busy128, 1'b0);
    checkVal("rst_pt", pt128, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkBit("rel_inReady", inReady, 1'b1);

    $display("[TB] AES-128 known answer");
    applyStimulus(CT_V1, KEY_V1, PT_V, 51, 1'b0, "aes128");
    checkOutput("aes128");
    finishHandshake("aes128");

    $display("[TB] AES-192 and AES-256 known answers");
    @(negedge clk);
    inValidB = 1'b1;
    checkBit("aes192_inReady", inReady192, 1'b1);
    checkBit("aes256_inReady", inReady256, 1'b1);
    @(posedge clk);
    #1;
    inValidB = 1'b0;
    cnt = 0;
    lat192 = -1;
    lat256 = -1;
    while ((lat192 < 0 || lat256 < 0) && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (outValid192 && lat192 < 0) lat192 = cnt;
      if (outValid256 && lat256 < 0) lat256 = cnt;
    end
    checkInt("aes192_latency", lat192, 59);
    checkInt("aes256_latency", lat256, 67);
    checkVal("aes192_pt", pt192, PT_V);
    checkVal("aes256_pt", pt256, PT_V);
    repeat (2) @(posedge clk);
    #1;
    checkBit("aes192_idle", busy192, 1'b0);
    checkBit("aes256_idle", busy256, 1'b0);

    $display("[TB] backpressure with in_valid held");
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(CT_B, KEY_B, PT_B, 51, 1'b1, "bp");
    checkOutput("bp");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkBit("bp_holdValid", outValid, 1'b1);
      checkVal("bp_holdPt", pt128, PT_B);
      checkBit("bp_holdInReady", inReady, 1'b0);
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    finishHandshake("bp");
    @(posedge clk);
    #1;
    checkBit("bp_idleOutValid", outValid, 1'b0);
    checkBit("bp_idleBusy", busy128, 1'b0);
    checkVal("bp_ptKept", pt128, PT_B);

    $display("[TB] asynchronous reset during key expansion");
    applyStimulus(CT_V1, KEY_V1, PT_V, 51, 1'b0, "abort");
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkBit("abort_outValid", outValid, 1'b0);
    checkBit("abort_busy", busy128, 1'b0);
    checkVal("abort_pt", pt128, 128'h0);
    checkBit("abort_inReady", inReady, 1'b0);
    sbQ.delete();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(CT_V1, KEY_V1, PT_V, 51, 1'b0, "postRst");
    checkOutput("postRst");
    finishHandshake("postRst");

    $display("[TB] repeated key sequence");
    applyStimulus(CT_B, KEY_B, PT_B, 51, 1'b0, "seqB1");
    checkOutput("seqB1");
    finishHandshake("seqB1");
    applyStimulus(CT_V1, KEY_V1, PT_V, 51, 1'b0, "seqV1a");
    checkOutput("seqV1a");
    finishHandshake("seqV1a");
    applyStimulus(CT_V1, KEY_V1, PT_V, CACHED_LAT, 1'b0, "seqV1b");
    checkOutput("seqV1b");
    finishHandshake("seqV1b");
    applyStimulus(CT_B, KEY_B, PT_B, 51, 1'b0, "seqB2");
    checkOutput("seqB2");
    finishHandshake("seqB2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
